// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN input feeder: default widths, derived
// pointer/count widths and the feeder FSM state encoding.
package rnn_pkg;

    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 16;

    // Pointer width indexes DEPTH entries; count needs one extra bit to hold DEPTH.
    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF = PTR_W_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/rnn_sync_fifo.sv
// Single-clock FIFO holding input vectors. The head entry is presented
// combinationally so the consumer can latch it in the same cycle it pops.
module rnn_sync_fifo
    import rnn_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wr_data,
    output logic [DW-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // A full FIFO never takes a push, even when a pop frees a slot this cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are only visible through count-gated reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy independently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rnn_input_feeder.sv
// Buffers host input vectors and serves them to the RNN core one per time
// step through the core's ready/busy/i_en/idata handshake.
//
// state | meaning
// IDLE  | no run; i_en ignored, start arms a run and clears underflow
// ARM   | run requested; ready raised while vectors are queued, waits for busy
// RUN   | core running; each i_en pops the head, busy low ends the run
module rnn_input_feeder
    import rnn_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       s_valid,
    input  logic [DW-1:0]              s_data,
    output logic                       s_ready,
    input  logic                       start,
    output logic                       ready,
    input  logic                       busy,
    input  logic                       i_en,
    output logic [DW-1:0]              idata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       underflow,
    output logic                       done
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state;
    state_t        state_nxt;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [DW-1:0] head;
    logic [CW-1:0] count_nxt;
    logic          ready_d;
    logic          done_d;
    logic          uf_set;
    logic          uf_clr;

    rnn_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_data (s_data),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign s_ready   = ~full;
    assign push      = s_valid & ~full;
    assign idata     = empty ? '0 : head;
    // Occupancy after this edge, so ready reflects a push in the same cycle.
    assign count_nxt = count + CW'(push) - CW'(pop);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     if (busy)  state_nxt = RUN;
            RUN:     if (!busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state outputs: pop qualification, underflow set/clear, done and ready.
    always_comb begin
        pop     = 1'b0;
        uf_set  = 1'b0;
        uf_clr  = 1'b0;
        done_d  = 1'b0;
        ready_d = (state_nxt == ARM) && (count_nxt != '0);
        case (state)
            IDLE: uf_clr = start;
            RUN: begin
                pop    = i_en & ~empty;
                uf_set = i_en & empty;
                done_d = ~busy;
            end
            default: ;
        endcase
    end

    // Registered handshake and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready     <= 1'b0;
            done      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ready <= ready_d;
            done  <= done_d;
            if (uf_set) begin
                underflow <= 1'b1;
            end else if (uf_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rnn_input_feeder.sv
// Directed self-checking bench for rnn_input_feeder. Inputs change on the
// falling edge; outputs are sampled on the falling edge as well.
module tb_rnn_input_feeder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        start;
    logic        ready;
    logic        busy;
    logic        i_en;
    logic [31:0] idata;
    logic [4:0]  count;
    logic        underflow;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;

    rnn_input_feeder #(.DEPTH(16), .DW(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .start     (start),
        .ready     (ready),
        .busy      (busy),
        .i_en      (i_en),
        .idata     (idata),
        .count     (count),
        .underflow (underflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push1(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
    endtask

    logic [31:0] vec3 [3];
    logic [31:0] q [$];
    int          pushed;
    int          mcount;
    logic        acc;

    initial begin
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        start   = 1'b0;
        busy    = 1'b0;
        i_en    = 1'b0;
        vec3[0] = 32'h0000_0001;
        vec3[1] = 32'hFFFF_FFFF;
        vec3[2] = 32'hA5A5_A5A5;

        // Reset values
        step();
        chk("rst_ready", ready, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_idata", idata, 0);
        chk("rst_sready", s_ready, 1);
        reset_n = 1'b1;
        step();

        // Basic run: three vectors, i_en spaced 100 cycles apart
        for (int i = 0; i < 3; i++) push1(vec3[i]);
        chk("t1_count3", count, 3);
        chk("t1_head", idata, 32'h0000_0001);
        chk("t1_idle_ready", ready, 0);
        i_en = 1'b1;                       // i_en in IDLE: ignored
        step();
        i_en = 1'b0;
        chk("t1_idle_ien_count", count, 3);
        chk("t1_idle_ien_ready", ready, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_ready_after_start", ready, 1);
        i_en = 1'b1;                       // i_en in ARM: ignored
        step();
        i_en = 1'b0;
        chk("t1_arm_ien_count", count, 3);
        chk("t1_arm_ready", ready, 1);
        busy = 1'b1;
        step();
        chk("t1_ready_drop", ready, 0);
        start = 1'b1;                      // start in RUN: ignored
        step();
        start = 1'b0;
        chk("t1_run_start_count", count, 3);
        chk("t1_run_start_ready", ready, 0);
        for (int k = 0; k < 3; k++) begin
            repeat (100) step();
            chk("t1_idata", idata, vec3[k]);
            i_en = 1'b1;
            step();
            i_en = 1'b0;
            chk("t1_count_dec", count, 32'(2 - k));
            chk("t1_no_done", done, 0);
        end
        chk("t1_empty_idata", idata, 0);
        chk("t1_uf", underflow, 0);
        busy = 1'b0;
        step();
        chk("t1_done", done, 1);
        step();
        chk("t1_done_once", done, 0);

        // Empty start, then ready the cycle after a push; then underflow
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_ready_empty", ready, 0);
        push1(32'h1234_5678);
        chk("t3_ready_after_push", ready, 1);
        chk("t3_count1", count, 1);
        busy = 1'b1;
        step();
        chk("t3_idata", idata, 32'h1234_5678);
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        chk("t3_count0", count, 0);
        i_en = 1'b1;
        chk("t3_uf_idata", idata, 0);
        step();
        i_en = 1'b0;
        chk("t3_uf_set", underflow, 1);
        chk("t3_uf_count", count, 0);
        busy = 1'b0;
        step();
        chk("t3_done", done, 1);
        chk("t3_uf_sticky", underflow, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_uf_cleared", underflow, 0);
        busy = 1'b1;                       // leave ARM through an empty run
        step();
        busy = 1'b0;
        step();
        step();

        // Fill to full, then concurrent push/pop across pointer wrap
        pushed = 0;
        for (int i = 0; i < 16; i++) begin
            push1(32'h1000 + 32'(pushed));
            q.push_back(32'h1000 + 32'(pushed));
            pushed++;
        end
        chk("t2_full_count", count, 16);
        chk("t2_full_sready", s_ready, 0);
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        repeat (3) step();
        s_valid = 1'b0;
        chk("t2_full_hold_count", count, 16);
        chk("t2_full_head", idata, 32'h1000);
        start = 1'b1;
        step();
        start = 1'b0;
        busy = 1'b1;
        step();
        mcount = 16;
        for (int it = 0; it < 100 && (pushed < 40 || q.size() != 0); it++) begin
            s_valid = (pushed < 40);
            s_data  = 32'h1000 + 32'(pushed);
            i_en    = 1'b1;
            chk("t2_sready", s_ready, (mcount != 16) ? 1 : 0);
            chk("t2_idata", idata, q[0]);
            acc = s_valid && (mcount != 16);
            step();
            void'(q.pop_front());
            mcount--;
            if (acc) begin
                q.push_back(32'h1000 + 32'(pushed));
                pushed++;
                mcount++;
            end
            chk("t2_count", count, 32'(mcount));
        end
        s_valid = 1'b0;
        i_en    = 1'b0;
        chk("t2_pushed40", pushed, 40);
        chk("t2_drained", count, 0);
        chk("t2_no_uf", underflow, 0);
        busy = 1'b0;
        step();
        chk("t2_done", done, 1);
        step();

        // Reset mid-run with five entries queued
        for (int i = 0; i < 5; i++) push1(32'h5000 + 32'(i));
        chk("t6_count5", count, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        busy = 1'b1;
        step();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_ready", ready, 0);
        chk("t6_rst_idata", idata, 0);
        busy = 1'b0;
        step();
        chk("t6_rst_no_done", done, 0);
        reset_n = 1'b1;
        step();
        chk("t6_post_no_done", done, 0);
        push1(32'h6000_0001);
        chk("t6_idle_ready", ready, 0);
        chk("t6_post_count", count, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_post_ready", ready, 1);
        busy = 1'b1;
        step();
        chk("t6_post_idata", idata, 32'h6000_0001);
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        chk("t6_post_count0", count, 0);
        busy = 1'b0;
        step();
        chk("t6_post_done", done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
